// File: rtl/pixel_frame_receiver_pkg.sv
// Shared geometry, types and helpers for the pixel frame receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Sensor geometry is fixed here so the FIFO entry type and counter widths
// derive from a single place.
package pixel_frame_receiver_pkg;

    localparam int PIXEL_BITS         = 8;
    localparam int OUTPUT_BUS_WIDTH   = 4;
    localparam int PIXEL_ARRAY_WIDTH  = 16;
    localparam int PIXEL_ARRAY_HEIGHT = 16;
    localparam int FIFO_DEPTH         = 4;

    localparam int WORDS_PER_ROW   = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int WORDS_PER_FRAME = WORDS_PER_ROW * PIXEL_ARRAY_HEIGHT;

    localparam int X_BITS    = $clog2(PIXEL_ARRAY_WIDTH);
    localparam int Y_BITS    = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int COL_BITS  = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam int LANE_BITS = (OUTPUT_BUS_WIDTH > 1) ? $clog2(OUTPUT_BUS_WIDTH) : 1;
    // One extra value so the counter can hold WORDS_PER_FRAME itself.
    localparam int CNT_BITS  = $clog2(WORDS_PER_FRAME + 1);

    // Lane 0 is the leftmost pixel of the word.
    typedef logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0] bus_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RECEIVE,
        ST_DRAIN
    } rx_state_t;

    // A captured word travels with its raster position so that dropped words
    // never shift the coordinates of the words behind them.
    typedef struct packed {
        bus_word_t             data;
        logic [COL_BITS-1:0]   word_col;
        logic [Y_BITS-1:0]     row;
    } rx_word_t;

    function automatic logic [X_BITS-1:0] pixel_x(input logic [COL_BITS-1:0]  col,
                                                  input logic [LANE_BITS-1:0] lane);
        int x;
        x = int'(col) * OUTPUT_BUS_WIDTH + int'(lane);
        return X_BITS'(x);
    endfunction

endpackage

// File: rtl/pixel_rx_fifo.sv
// Synchronous FIFO of captured sensor words.
// Latency: a write is visible at the head one cycle later.
// Backpressure: writes while full are discarded; reads while empty are ignored.
//
// Ports: clk/rst (sync, active-high), wr_vld/wr_dat write side, full flag,
//        rd_en/rd_dat read side (head is combinational), empty flag.
module pixel_rx_fifo
    import pixel_frame_receiver_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_vld,
    input  rx_word_t wr_dat,
    output logic     full,
    input  logic     rd_en,
    output rx_word_t rd_dat,
    output logic     empty
);

    localparam int PTR_BITS = $clog2(DEPTH);

    // Pointers carry one wrap bit to tell full from empty.
    logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
    rx_word_t          mem_q [DEPTH];
    rx_word_t          mem_d [DEPTH];
    logic              wr_en;
    logic              rd_go;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
        wr_en = wr_vld && !full;
        rd_go = rd_en && !empty;

        rd_dat   = mem_q[rd_ptr_q[PTR_BITS-1:0]];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (wr_en) begin
            mem_d[wr_ptr_q[PTR_BITS-1:0]] = wr_dat;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_go) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pixel_frame_receiver.sv
// Receives sensor bus words and streams them out one pixel at a time with raster (x,y).
// Latency: first pixel valid two cycles after the synchronised OUTPUT_CLK rise is seen.
// Backpressure: PIXEL_READY stalls the serialiser; words arriving with the FIFO full are dropped and flagged.
//
// Ports: CLK/RESET (sync, active-high); ENABLE arms capture; OUTPUT_CLK, DATA_IN and
//        FRAME_FINISHED come from the sensor asynchronously; PIXEL_* is the valid/ready
//        pixel stream; FRAME_DONE pulses once per finished frame; ERR_* are sticky.
module pixel_frame_receiver
    import pixel_frame_receiver_pkg::*;
(
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic                                         ENABLE,
    input  logic                                         OUTPUT_CLK,
    input  logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  DATA_IN,
    input  logic                                         FRAME_FINISHED,
    output logic [PIXEL_BITS-1:0]                        PIXEL_OUT,
    output logic [X_BITS-1:0]                            PIXEL_X,
    output logic [Y_BITS-1:0]                            PIXEL_Y,
    output logic                                         PIXEL_VALID,
    input  logic                                         PIXEL_READY,
    output logic                                         PIXEL_LAST,
    output logic                                         FRAME_DONE,
    output logic                                         ERR_OVERFLOW,
    output logic                                         ERR_LENGTH
);

    // Synchronisers plus one history flop each for edge detection.
    logic oclk_meta_q, oclk_meta_d, oclk_sync_q, oclk_sync_d, oclk_hist_q, oclk_hist_d;
    logic ff_meta_q, ff_meta_d, ff_sync_q, ff_sync_d, ff_hist_q, ff_hist_d;

    rx_state_t             state_q, state_d;
    logic [COL_BITS-1:0]   word_col_q, word_col_d;
    logic [Y_BITS-1:0]     row_q, row_d;
    logic [CNT_BITS-1:0]   word_cnt_q, word_cnt_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_len_q, err_len_d;
    logic                  frame_done_q, frame_done_d;

    logic                  ser_vld_q, ser_vld_d;
    rx_word_t              ser_word_q, ser_word_d;
    logic [LANE_BITS-1:0]  lane_q, lane_d;

    logic                  oclk_rise;
    logic                  ff_rise;
    logic                  ff_fall;
    logic                  capture;
    logic                  handshake;
    logic                  last_lane;
    logic                  load;
    logic [X_BITS-1:0]     pix_x;

    rx_word_t              fifo_wr_dat;
    rx_word_t              fifo_rd_dat;
    logic                  fifo_full;
    logic                  fifo_empty;

    pixel_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RESET),
        .wr_vld (capture),
        .wr_dat (fifo_wr_dat),
        .full   (fifo_full),
        .rd_en  (load),
        .rd_dat (fifo_rd_dat),
        .empty  (fifo_empty)
    );

    always_comb begin
        oclk_meta_d = OUTPUT_CLK;
        oclk_sync_d = oclk_meta_q;
        oclk_hist_d = oclk_sync_q;
        ff_meta_d   = FRAME_FINISHED;
        ff_sync_d   = ff_meta_q;
        ff_hist_d   = ff_sync_q;

        oclk_rise = oclk_sync_q & ~oclk_hist_q;
        ff_rise   = ff_sync_q & ~ff_hist_q;
        ff_fall   = ~ff_sync_q & ff_hist_q;

        // DATA_IN is sampled in the very cycle the strobe edge is seen;
        // the sensor holds it long enough for the synchroniser delay.
        capture              = oclk_rise && (state_q == ST_RECEIVE);
        fifo_wr_dat.data     = DATA_IN;
        fifo_wr_dat.word_col = word_col_q;
        fifo_wr_dat.row      = row_q;

        state_d      = state_q;
        word_col_d   = word_col_q;
        row_d        = row_q;
        word_cnt_d   = word_cnt_q;
        err_ovf_d    = err_ovf_q;
        err_len_d    = err_len_q;
        frame_done_d = 1'b0;

        // Counters advance on every capture, dropped or not, so positions
        // of later words stay true to the sensor raster.
        if (capture) begin
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_col_q == COL_BITS'(WORDS_PER_ROW - 1)) begin
                word_col_d = '0;
                row_d      = row_q + 1'b1;
            end else begin
                word_col_d = word_col_q + 1'b1;
            end
            if (fifo_full) begin
                err_ovf_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ENABLE) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!ENABLE) begin
                    state_d = ST_IDLE;
                end else if (ff_fall) begin
                    state_d    = ST_RECEIVE;
                    word_col_d = '0;
                    row_d      = '0;
                    word_cnt_d = '0;
                end
            end
            ST_RECEIVE: begin
                // Using the post-capture count lets a final word that
                // coincides with the FRAME_FINISHED rise count as complete.
                if ((word_cnt_d == CNT_BITS'(WORDS_PER_FRAME)) || ff_rise) begin
                    state_d = ST_DRAIN;
                end
                if (ff_rise && (word_cnt_d < CNT_BITS'(WORDS_PER_FRAME))) begin
                    err_len_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !ser_vld_q) begin
                    frame_done_d = 1'b1;
                    state_d      = ENABLE ? ST_ARMED : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Serialiser: refilling on the last-lane handshake avoids a bubble
        // between consecutive words.
        handshake = ser_vld_q && PIXEL_READY;
        last_lane = (lane_q == LANE_BITS'(OUTPUT_BUS_WIDTH - 1));
        load      = !fifo_empty && (!ser_vld_q || (handshake && last_lane));

        ser_vld_d  = ser_vld_q;
        ser_word_d = ser_word_q;
        lane_d     = lane_q;

        if (load) begin
            ser_vld_d  = 1'b1;
            ser_word_d = fifo_rd_dat;
            lane_d     = '0;
        end else if (handshake) begin
            if (last_lane) begin
                ser_vld_d = 1'b0;
                lane_d    = '0;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end

        pix_x       = pixel_x(ser_word_q.word_col, lane_q);
        PIXEL_OUT   = ser_word_q.data[lane_q];
        PIXEL_X     = pix_x;
        PIXEL_Y     = ser_word_q.row;
        PIXEL_VALID = ser_vld_q;
        PIXEL_LAST  = ser_vld_q &&
                      (pix_x == X_BITS'(PIXEL_ARRAY_WIDTH - 1)) &&
                      (ser_word_q.row == Y_BITS'(PIXEL_ARRAY_HEIGHT - 1));
        FRAME_DONE   = frame_done_q;
        ERR_OVERFLOW = err_ovf_q;
        ERR_LENGTH   = err_len_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            oclk_meta_q  <= 1'b0;
            oclk_sync_q  <= 1'b0;
            oclk_hist_q  <= 1'b0;
            ff_meta_q    <= 1'b0;
            ff_sync_q    <= 1'b0;
            ff_hist_q    <= 1'b0;
            state_q      <= ST_IDLE;
            word_col_q   <= '0;
            row_q        <= '0;
            word_cnt_q   <= '0;
            err_ovf_q    <= 1'b0;
            err_len_q    <= 1'b0;
            frame_done_q <= 1'b0;
            ser_vld_q    <= 1'b0;
            ser_word_q   <= '0;
            lane_q       <= '0;
        end else begin
            oclk_meta_q  <= oclk_meta_d;
            oclk_sync_q  <= oclk_sync_d;
            oclk_hist_q  <= oclk_hist_d;
            ff_meta_q    <= ff_meta_d;
            ff_sync_q    <= ff_sync_d;
            ff_hist_q    <= ff_hist_d;
            state_q      <= state_d;
            word_col_q   <= word_col_d;
            row_q        <= row_d;
            word_cnt_q   <= word_cnt_d;
            err_ovf_q    <= err_ovf_d;
            err_len_q    <= err_len_d;
            frame_done_q <= frame_done_d;
            ser_vld_q    <= ser_vld_d;
            ser_word_q   <= ser_word_d;
            lane_q       <= lane_d;
        end
    end

endmodule

// File: tb/tb_pixel_frame_receiver.sv
// Self-checking bench for pixel_frame_receiver: scenario table plus hand sequences.
// Latency: n/a.
// Backpressure: PIXEL_READY driven constant, random, or with a long stall window.
module tb_pixel_frame_receiver;
    import pixel_frame_receiver_pkg::*;

    logic      clk = 1'b0;
    always #5 clk = ~clk;

    logic      RESET, ENABLE, OUTPUT_CLK, FRAME_FINISHED, PIXEL_READY;
    bus_word_t DATA_IN;
    logic [PIXEL_BITS-1:0] PIXEL_OUT;
    logic [X_BITS-1:0]     PIXEL_X;
    logic [Y_BITS-1:0]     PIXEL_Y;
    logic PIXEL_VALID, PIXEL_LAST, FRAME_DONE, ERR_OVERFLOW, ERR_LENGTH;

    pixel_frame_receiver dut (
        .CLK(clk), .RESET(RESET), .ENABLE(ENABLE), .OUTPUT_CLK(OUTPUT_CLK),
        .DATA_IN(DATA_IN), .FRAME_FINISHED(FRAME_FINISHED),
        .PIXEL_OUT(PIXEL_OUT), .PIXEL_X(PIXEL_X), .PIXEL_Y(PIXEL_Y),
        .PIXEL_VALID(PIXEL_VALID), .PIXEL_READY(PIXEL_READY), .PIXEL_LAST(PIXEL_LAST),
        .FRAME_DONE(FRAME_DONE), .ERR_OVERFLOW(ERR_OVERFLOW), .ERR_LENGTH(ERR_LENGTH)
    );

    // One sensor word as the sensor sent it, with its place in the raster.
    typedef struct {
        bus_word_t data;
        int        col;
        int        row;
    } exp_word_t;

    // Scenario record: stimulus knobs followed by expected outcomes (-1 = not checked).
    typedef struct {
        int n_words;
        int same_ff;
        int stall_word;
        int rnd_ready;
        int exp_pixels;
        int exp_last_cnt;
        int exp_len_err;
        int exp_drop;
        int exp_lx;
        int exp_ly;
    } vec_t;

    vec_t      vecs [6];
    exp_word_t exp_q [$];
    exp_word_t cur;
    int        cur_lane;
    int        checks, errors, cyc, stall_until, rand_ready;
    int        dropped, pix_cnt, last_cnt, done_cnt, vld_cycles, last_x, last_y;
    logic      prev_vld, prev_rdy, prev_last;
    logic [PIXEL_BITS-1:0] prev_pix;
    logic [X_BITS-1:0]     prev_x;
    logic [Y_BITS-1:0]     prev_y;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_word_t make_word(input int i);
        exp_word_t w;
        w.data = $urandom();
        w.col  = i % WORDS_PER_ROW;
        w.row  = i / WORDS_PER_ROW;
        return w;
    endfunction

    // Scoreboard: each accepted pixel must be the next lane of the next word
    // the sensor sent; whole words may be missing (dropped), nothing else.
    task automatic handshake();
        int ex, ey;
        logic el;
        pix_cnt++;
        last_x = int'(PIXEL_X);
        last_y = int'(PIXEL_Y);
        if (PIXEL_LAST) last_cnt++;
        if (cur_lane == 0) begin
            while (exp_q.size() > 0 &&
                   !(exp_q[0].col * OUTPUT_BUS_WIDTH == int'(PIXEL_X) && exp_q[0].row == int'(PIXEL_Y))) begin
                void'(exp_q.pop_front());
                dropped++;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d with no matching word pending", PIXEL_X, PIXEL_Y);
                return;
            end
            cur = exp_q.pop_front();
        end
        ex = cur.col * OUTPUT_BUS_WIDTH + cur_lane;
        ey = cur.row;
        el = (ex == PIXEL_ARRAY_WIDTH - 1) && (ey == PIXEL_ARRAY_HEIGHT - 1);
        chk("pixel{val,x,y,last}", {PIXEL_OUT, PIXEL_X, PIXEL_Y, PIXEL_LAST},
            {cur.data[cur_lane], X_BITS'(ex), Y_BITS'(ey), el});
        cur_lane = (cur_lane + 1) % OUTPUT_BUS_WIDTH;
    endtask

    task automatic monitor_sample();
        if (PIXEL_VALID) vld_cycles++;
        if (FRAME_DONE) done_cnt++;
        if (prev_vld && !prev_rdy) begin
            chk("valid_held_in_stall", PIXEL_VALID, 1);
            if (PIXEL_VALID)
                chk("outputs_held_in_stall", {PIXEL_OUT, PIXEL_X, PIXEL_Y, PIXEL_LAST},
                    {prev_pix, prev_x, prev_y, prev_last});
        end
        if (PIXEL_VALID && PIXEL_READY) handshake();
        prev_vld  = PIXEL_VALID;
        prev_rdy  = PIXEL_READY;
        prev_pix  = PIXEL_OUT;
        prev_x    = PIXEL_X;
        prev_y    = PIXEL_Y;
        prev_last = PIXEL_LAST;
    endtask

    // One clock: sample outputs at the falling edge, drive inputs 1 after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor_sample();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < stall_until)   PIXEL_READY = 1'b0;
        else if (rand_ready != 0) PIXEL_READY = ($urandom_range(0, 3) != 0);
        else                     PIXEL_READY = 1'b1;
    endtask

    task automatic clear_stats();
        exp_q.delete();
        cur_lane = 0; dropped = 0; pix_cnt = 0; last_cnt = 0;
        done_cnt = 0; vld_cycles = 0; last_x = -1; last_y = -1;
    endtask

    task automatic reset_dut();
        RESET = 1'b1;
        stall_until = 0;
        step();
        RESET = 1'b0;
        prev_vld = 1'b0;
        clear_stats();
        chk("reset_outputs", {PIXEL_VALID, PIXEL_LAST, FRAME_DONE, ERR_OVERFLOW, ERR_LENGTH,
                              PIXEL_OUT, PIXEL_X, PIXEL_Y}, 0);
        chk("reset_state_idle", int'(dut.state_q), int'(ST_IDLE));
    endtask

    // Sensor word: data set up first, strobe high 4 CLK, low 4 CLK.
    task automatic send_word(input exp_word_t w, input bit with_ff, input bit want);
        DATA_IN = w.data;
        step();
        OUTPUT_CLK = 1'b1;
        if (with_ff) FRAME_FINISHED = 1'b1;
        if (want) exp_q.push_back(w);
        repeat (4) step();
        OUTPUT_CLK = 1'b0;
        repeat (3) step();
    endtask

    task automatic run_frame(input int n, input int same_ff, input int stall_word,
                             input int en_drop_word, input bit want);
        FRAME_FINISHED = 1'b0;
        repeat (6) step();
        for (int i = 0; i < n; i++) begin
            if (i == stall_word) stall_until = cyc + 56;
            if (i == en_drop_word) ENABLE = 1'b0;
            send_word(make_word(i), (same_ff != 0) && (i == n - 1), want);
        end
        if (same_ff == 0) begin
            repeat (3) step();
            FRAME_FINISHED = 1'b1;
        end
    endtask

    // Waits (bounded) for FRAME_DONE, then makes sure it pulsed exactly once.
    task automatic finish_frame();
        int t;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            step();
            t++;
        end
        repeat (20) step();
        chk("frame_done_pulses", done_cnt, 1);
        dropped += exp_q.size();
        exp_q.delete();
        chk("no_partial_word", cur_lane, 0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; stall_until = 0; rand_ready = 0;
        RESET = 1'b0; ENABLE = 1'b0; OUTPUT_CLK = 1'b0; DATA_IN = '0;
        FRAME_FINISHED = 1'b1; PIXEL_READY = 1'b1;
        prev_vld = 1'b0; prev_rdy = 1'b1; prev_last = 1'b0;
        prev_pix = '0; prev_x = '0; prev_y = '0;
        clear_stats();

        //          words same stall rnd  pix  last len drop lx  ly
        vecs[0] = '{64,   0,   -1,   0,  256, 1,   0,  0,   15, 15};  // clean frame
        vecs[1] = '{60,   0,   -1,   0,  240, 0,   1,  0,   15, 14};  // short frame
        vecs[2] = '{64,   1,   -1,   0,  256, 1,   0,  0,   15, 15};  // last word with FF rise
        vecs[3] = '{64,   0,   20,   0,  -1,  1,   0,  1,   15, 15};  // long stall -> drops
        vecs[4] = '{64,   0,   -1,   1,  -1,  -1,  0,  -1,  -1, -1};  // random READY
        vecs[5] = '{64,   0,   -1,   1,  -1,  -1,  0,  -1,  -1, -1};  // random READY

        @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) begin
            reset_dut();
            ENABLE = 1'b1;
            rand_ready = vecs[k].rnd_ready;
            repeat (6) step();
            clear_stats();
            run_frame(vecs[k].n_words, vecs[k].same_ff, vecs[k].stall_word, -1, 1'b1);
            finish_frame();
            if (vecs[k].exp_pixels >= 0) chk("pixel_count", pix_cnt, vecs[k].exp_pixels);
            if (vecs[k].exp_last_cnt >= 0) chk("last_count", last_cnt, vecs[k].exp_last_cnt);
            chk("err_length", ERR_LENGTH, vecs[k].exp_len_err);
            chk("err_overflow_vs_drops", ERR_OVERFLOW, dropped > 0);
            if (vecs[k].exp_drop >= 0) chk("words_dropped", dropped > 0, vecs[k].exp_drop);
            if (vecs[k].exp_lx >= 0) chk("last_pixel_xy", {last_x[7:0], last_y[7:0]},
                                         {vecs[k].exp_lx[7:0], vecs[k].exp_ly[7:0]});
        end
        rand_ready = 0;

        // Reset in the middle of a frame: nothing more until a fresh frame start.
        reset_dut();
        ENABLE = 1'b1;
        repeat (6) step();
        clear_stats();
        FRAME_FINISHED = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 30; i++) send_word(make_word(i), 1'b0, 1'b1);
        reset_dut();
        for (int i = 30; i < 64; i++) send_word(make_word(i), 1'b0, 1'b0);
        FRAME_FINISHED = 1'b1;
        repeat (20) step();
        chk("no_valid_after_midframe_reset", vld_cycles, 0);
        chk("no_done_after_midframe_reset", done_cnt, 0);
        run_frame(64, 0, -1, -1, 1'b1);
        finish_frame();
        chk("recovered_frame_pixels", pix_cnt, 256);

        // ENABLE low with traffic, then raised mid-frame: frame ignored.
        reset_dut();
        ENABLE = 1'b0;
        repeat (6) step();
        FRAME_FINISHED = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 10; i++) send_word(make_word(i), 1'b0, 1'b0);
        chk("no_valid_while_disabled", vld_cycles, 0);
        ENABLE = 1'b1;
        for (int i = 10; i < 20; i++) send_word(make_word(i), 1'b0, 1'b0);
        FRAME_FINISHED = 1'b1;
        repeat (10) step();
        chk("no_valid_after_late_enable", vld_cycles, 0);
        chk("armed_after_late_enable", int'(dut.state_q), int'(ST_ARMED));
        chk("no_len_err_outside_frame", ERR_LENGTH, 0);
        run_frame(64, 0, -1, -1, 1'b1);
        finish_frame();
        chk("frame_after_late_enable_pixels", pix_cnt, 256);
        chk("frame_after_late_enable_last", last_cnt, 1);

        // ENABLE dropped mid-frame: frame still completes, then idle.
        reset_dut();
        ENABLE = 1'b1;
        repeat (6) step();
        clear_stats();
        run_frame(64, 0, -1, 10, 1'b1);
        finish_frame();
        chk("enable_drop_frame_pixels", pix_cnt, 256);
        chk("idle_after_enable_drop", int'(dut.state_q), int'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
